// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Free-running VGA pixel/line counters with registered sync and
//            blank flags aligned to the counts. Optional frame_start pulse
//            is built when VGA_FRAME_TICK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
`ifdef VGA_FRAME_TICK_EN
    output logic        frame_start,
`endif
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        h_blank_out,
    output logic        v_blank_out
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] c_H_LAST       = 11'(c_H_TOTAL - 1);
    localparam logic [10:0] c_V_LAST       = 11'(c_V_TOTAL - 1);
    // Thresholds are 12 bits so a sync window ending exactly at 2048 stays exact
    localparam logic [11:0] c_H_ACT        = 12'(H_ACTIVE);
    localparam logic [11:0] c_H_SYNC_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_V_ACT        = 12'(V_ACTIVE);
    localparam logic [11:0] c_V_SYNC_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (c_H_TOTAL > 2048 || c_V_TOTAL > 2048) begin : g_total_check
            $error("vga_timing_gen: H or V total exceeds 2048");
        end
    endgenerate

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_h_sync;
    logic        r_v_sync;
    logic        r_h_blank;
    logic        r_v_blank;

    logic        w_h_last;
    logic        w_v_last;
    logic [10:0] w_h_next;
    logic [10:0] w_v_next;
    logic [11:0] w_h_next_x;
    logic [11:0] w_v_next_x;
    logic        w_h_sync_act;
    logic        w_v_sync_act;

    always_comb begin
        w_h_last     = (r_hcount == c_H_LAST);
        w_v_last     = (r_vcount == c_V_LAST);
        w_h_next     = w_h_last ? 11'd0 : r_hcount + 11'd1;
        w_v_next     = r_vcount;
        if (w_h_last) begin
            w_v_next = w_v_last ? 11'd0 : r_vcount + 11'd1;
        end
        w_h_next_x   = {1'b0, w_h_next};
        w_v_next_x   = {1'b0, w_v_next};
        w_h_sync_act = (w_h_next_x >= c_H_SYNC_START) && (w_h_next_x < c_H_SYNC_END);
        w_v_sync_act = (w_v_next_x >= c_V_SYNC_START) && (w_v_next_x < c_V_SYNC_END);
    end

    // Flags are derived from the next counts so they land with the counts they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcount  <= 11'd0;
            r_vcount  <= 11'd0;
            r_h_sync  <= ~SYNC_POL;
            r_v_sync  <= ~SYNC_POL;
            r_h_blank <= 1'b0;
            r_v_blank <= 1'b0;
        end else if (en) begin
            r_hcount  <= w_h_next;
            r_vcount  <= w_v_next;
            r_h_sync  <= w_h_sync_act ? SYNC_POL : ~SYNC_POL;
            r_v_sync  <= w_v_sync_act ? SYNC_POL : ~SYNC_POL;
            r_h_blank <= (w_h_next_x >= c_H_ACT);
            r_v_blank <= (w_v_next_x >= c_V_ACT);
        end
    end

`ifdef VGA_FRAME_TICK_EN
    logic r_frame_start;

    // Cleared whenever en is low, so the pulse never outlasts one clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= en && w_h_last && w_v_last;
        end
    end

    assign frame_start = r_frame_start;
`endif

    assign hcount_out  = r_hcount;
    assign vcount_out  = r_vcount;
    assign h_sync_out  = r_h_sync;
    assign v_sync_out  = r_v_sync;
    assign h_blank_out = r_h_blank;
    assign v_blank_out = r_v_blank;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed bench: default 800x600 timing instance plus a small
//            active-low-sync instance used for full-frame checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;

    logic [10:0] hc_a, vc_a, hc_b, vc_b;
    logic        hs_a, vs_a, hb_a, vb_a;
    logic        hs_b, vs_b, hb_b, vb_b;
`ifdef VGA_FRAME_TICK_EN
    logic        fs_a, fs_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    int exp_ha, exp_va, exp_hb, exp_vb;
    bit exp_fa, exp_fb;
    int hs_cnt, hb_cnt, vs_cnt, vb_cnt, fs_cnt;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
`ifdef VGA_FRAME_TICK_EN
        .frame_start (fs_a),
`endif
        .hcount_out  (hc_a),
        .vcount_out  (vc_a),
        .h_sync_out  (hs_a),
        .v_sync_out  (vs_a),
        .h_blank_out (hb_a),
        .v_blank_out (vb_a)
    );

    // Small timing: H total 10 (sync 6..8), V total 7 (sync 4..5), active-low sync
    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (2), .H_SYNC (3), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b0)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
`ifdef VGA_FRAME_TICK_EN
        .frame_start (fs_b),
`endif
        .hcount_out  (hc_b),
        .vcount_out  (vc_b),
        .h_sync_out  (hs_b),
        .v_sync_out  (vs_b),
        .h_blank_out (hb_b),
        .v_blank_out (vb_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("a_hcount",  32'(hc_a), 32'(exp_ha));
        check_val("a_vcount",  32'(vc_a), 32'(exp_va));
        check_val("a_hsync",   32'(hs_a), 32'(exp_ha >= 840 && exp_ha < 968));
        check_val("a_hblank",  32'(hb_a), 32'(exp_ha >= 800));
        check_val("a_vsync",   32'(vs_a), 32'(exp_va >= 601 && exp_va < 605));
        check_val("a_vblank",  32'(vb_a), 32'(exp_va >= 600));
        check_val("b_hcount",  32'(hc_b), 32'(exp_hb));
        check_val("b_vcount",  32'(vc_b), 32'(exp_vb));
        check_val("b_hsync",   32'(hs_b), 32'(!(exp_hb >= 6 && exp_hb < 9)));
        check_val("b_hblank",  32'(hb_b), 32'(exp_hb >= 4));
        check_val("b_vsync",   32'(vs_b), 32'(!(exp_vb >= 4 && exp_vb < 6)));
        check_val("b_vblank",  32'(vb_b), 32'(exp_vb >= 3));
`ifdef VGA_FRAME_TICK_EN
        check_val("a_frame_start", 32'(fs_a), 32'(exp_fa));
        check_val("b_frame_start", 32'(fs_b), 32'(exp_fb));
`endif
    endtask

    task automatic model_reset();
        exp_ha = 0; exp_va = 0; exp_hb = 0; exp_vb = 0;
        exp_fa = 1'b0; exp_fb = 1'b0;
    endtask

    task automatic tally_reset();
        hs_cnt = 0; hb_cnt = 0; vs_cnt = 0; vb_cnt = 0; fs_cnt = 0;
    endtask

    task automatic tick(input bit e);
        @(negedge clk);
        en = e;
        @(posedge clk);
        #1;
        exp_fa = e && (exp_ha == 1055) && (exp_va == 627);
        exp_fb = e && (exp_hb == 9) && (exp_vb == 6);
        if (e) begin
            if (exp_ha == 1055) begin
                exp_ha = 0;
                exp_va = (exp_va == 627) ? 0 : exp_va + 1;
            end else begin
                exp_ha++;
            end
            if (exp_hb == 9) begin
                exp_hb = 0;
                exp_vb = (exp_vb == 6) ? 0 : exp_vb + 1;
            end else begin
                exp_hb++;
            end
        end
        check_all();
        if (hs_a)  hs_cnt++;
        if (hb_a)  hb_cnt++;
        if (!vs_b) vs_cnt++;
        if (vb_b)  vb_cnt++;
`ifdef VGA_FRAME_TICK_EN
        if (fs_b)  fs_cnt++;
`endif
    endtask

    // Asynchronous assertion away from any clock edge, checked before the next edge
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        model_reset();
        tally_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();

        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        release_rst();
        tick(1'b1);
        repeat (499) tick(1'b1);

        async_reset();
        release_rst();
        tally_reset();
        repeat (1056) tick(1'b1);
        check_val("a_hsync_cycles",  32'(hs_cnt), 32'd128);
        check_val("a_hblank_cycles", 32'(hb_cnt), 32'd256);

        async_reset();
        release_rst();
        tally_reset();
        repeat (70) tick(1'b1);
        check_val("b_vsync_cycles",  32'(vs_cnt), 32'd20);
        check_val("b_vblank_cycles", 32'(vb_cnt), 32'd40);
`ifdef VGA_FRAME_TICK_EN
        check_val("b_frame_pulses",  32'(fs_cnt), 32'd1);
`endif

        tally_reset();
        for (int i = 0; i < 280; i++) begin
            tick(i % 4 == 0);
        end
        check_val("b_vsync_cycles_en4",  32'(vs_cnt), 32'd80);
        check_val("b_vblank_cycles_en4", 32'(vb_cnt), 32'd160);
`ifdef VGA_FRAME_TICK_EN
        check_val("b_frame_pulses_en4",  32'(fs_cnt), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
